// File: rtl/ysyx_24070014_lsu.sv
// ysyx_24070014_lsu: non-pipelined RV32I load/store unit with lane alignment and extension
module ysyx_24070014_lsu #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_wen,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic [3:0]          mem_wmask,
  input  logic                mem_rvalid,
  input  logic [DATA_LEN-1:0] mem_rdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] resp_data,
  output logic                resp_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;
  state_t state, state_n;
  logic [2:0] f3;
  logic [1:0] off;
  logic [1:0] o;
  logic bad_f3, mis, bad;
  logic [3:0] wmask;
  logic [DATA_LEN-1:0] wdata, r, ext;
  assign req_ready  = state == IDLE;
  assign mem_valid  = state == REQ;
  assign resp_valid = state == RESP;
  always_comb begin
    o      = req_addr[1:0];
    bad_f3 = req_write ? (req_funct3[2] | &req_funct3[1:0])
                       : (&req_funct3[1:0] | (req_funct3[2] & req_funct3[1]));
    mis    = (req_funct3[1:0] == 2'b01 && o[0]) || (req_funct3[1:0] == 2'b10 && o != 2'b00);
    bad    = bad_f3 | mis;
    wmask  = !req_write ? 4'b0000 :
             req_funct3[1:0] == 2'b00 ? 4'b0001 << o :
             req_funct3[1:0] == 2'b01 ? 4'b0011 << o : 4'b1111;
    wdata  = !req_write ? '0 :
             req_funct3[1:0] == 2'b00 ? {{(DATA_LEN-8){1'b0}}, req_wdata[7:0]} << {o, 3'b000} :
             req_funct3[1:0] == 2'b01 ? {{(DATA_LEN-16){1'b0}}, req_wdata[15:0]} << {o, 3'b000} : req_wdata;
    r      = mem_rdata >> {off, 3'b000};
    ext    = f3[1:0] == 2'b00 ? {{(DATA_LEN-8){r[7] & ~f3[2]}}, r[7:0]} :
             f3[1:0] == 2'b01 ? {{(DATA_LEN-16){r[15] & ~f3[2]}}, r[15:0]} : r;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req_valid ? (bad ? RESP : REQ) : IDLE;
      REQ:     state_n = mem_ready ? (mem_wen ? RESP : WAIT_R) : REQ;
      WAIT_R:  state_n = mem_rvalid ? RESP : WAIT_R;
      default: state_n = resp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= 4'b0000;
      resp_data <= '0;
      resp_err  <= 1'b0;
      f3        <= 3'b000;
      off       <= 2'b00;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        mem_wen   <= req_write;
        mem_addr  <= {req_addr[ADDR_LEN-1:2], 2'b00};
        mem_wdata <= wdata;
        mem_wmask <= wmask;
        resp_data <= '0;
        resp_err  <= bad;
        f3        <= req_funct3;
        off       <= o;
      end
      if (state == WAIT_R && mem_rvalid) resp_data <= ext;
    end
  end
endmodule

// File: tb/tb_ysyx_24070014_lsu.sv
// tb_ysyx_24070014_lsu: scoreboard bench for the load/store unit
module tb_ysyx_24070014_lsu;
  logic clk = 0, reset = 0;
  logic req_valid = 0, req_write = 0, mem_ready = 0, mem_rvalid = 0, resp_ready = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
  logic req_ready, mem_valid, mem_wen, resp_valid, resp_err;
  logic [31:0] mem_addr, mem_wdata, resp_data;
  logic [3:0] mem_wmask;
  int passed = 0, total = 0;
  typedef struct {logic [31:0] data; logic err;} resp_t;
  resp_t sb[$];

  ysyx_24070014_lsu dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic is_bad(input logic w, input logic [2:0] f, input logic [1:0] o);
    logic legal_f;
    legal_f = w ? (f inside {3'b000, 3'b001, 3'b010}) : (f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    return !legal_f || ((f == 3'b001 || f == 3'b101) && o[0]) || (f == 3'b010 && o != 0);
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] f, input logic [1:0] o, input logic [31:0] d);
    logic [7:0] b;
    logic [15:0] h;
    b = o == 0 ? d[7:0] : o == 1 ? d[15:8] : o == 2 ? d[23:16] : d[31:24];
    h = o[1] ? d[31:16] : d[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] st_mask(input logic [2:0] f, input logic [1:0] o);
    case (f)
      3'b000:  return 4'b0001 << o;
      3'b001:  return 4'b0011 << o;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_data(input logic [3:0] m, input logic [1:0] o, input logic [31:0] wd);
    logic [31:0] d;
    d = 0;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (m == 4'b1111) ? i : i - int'(o);
      if (m[i]) d[8*i +: 8] = wd[8*k +: 8];
    end
    return d;
  endfunction

  task automatic access(input logic w, input logic [2:0] f, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int mdly, input int rdly);
    logic bad;
    resp_t e;
    logic [3:0] m;
    bad = is_bad(w, f, addr[1:0]);
    e.err = bad;
    e.data = (bad || w) ? 32'h0 : ld_model(f, addr[1:0], rd);
    sb.push_back(e);
    m = w ? st_mask(f, addr[1:0]) : 4'b0000;
    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_write = w; req_funct3 = f; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0; req_addr = 32'h5555_5555; req_wdata = 32'hAAAA_AAAA;
    if (bad) check("mem_valid_err", mem_valid, 0);
    else begin
      for (int i = 0; i <= mdly; i++) begin
        check("mem_valid", mem_valid, 1);
        check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        check("mem_wen", mem_wen, w);
        check("mem_wmask", mem_wmask, m);
        if (w) check("mem_wdata", mem_wdata, st_data(m, addr[1:0], wd));
        check("req_ready_busy", req_ready, 0);
        check("resp_valid_early", resp_valid, 0);
        if (i == mdly) begin mem_ready = 1; mem_rvalid = 1; mem_rdata = ~rd; end
        @(posedge clk); #1;
      end
      mem_ready = 0; mem_rvalid = 0;
      if (!w) begin
        check("mem_valid_wait", mem_valid, 0);
        check("resp_valid_wait", resp_valid, 0);
        mem_rvalid = 1; mem_rdata = rd;
        @(posedge clk); #1;
        mem_rvalid = 0;
      end
    end
    for (int i = 0; i <= rdly; i++) begin
      check("resp_valid", resp_valid, 1);
      check("req_ready_resp", req_ready, 0);
      if (sb.size() == 0) check("sb_empty", 1, 0);
      else begin
        check("resp_data", resp_data, sb[0].data);
        check("resp_err", resp_err, sb[0].err);
      end
      if (i == rdly) resp_ready = 1;
      @(posedge clk); #1;
    end
    if (sb.size() != 0) void'(sb.pop_front());
    resp_ready = 0;
    check("resp_valid_done", resp_valid, 0);
    check("req_ready_back", req_ready, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1;
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    access(0, 3'b010, 32'h8000_0008, 0, 32'hDEAD_BEEF, 0, 0);
    access(0, 3'b000, 32'h8000_0003, 0, 32'h8011_2233, 0, 0);
    access(0, 3'b100, 32'h8000_0003, 0, 32'h8011_2233, 0, 0);
    access(0, 3'b001, 32'h8000_0002, 0, 32'h9ABC_1234, 0, 0);
    access(0, 3'b101, 32'h8000_0002, 0, 32'h9ABC_1234, 0, 0);
    access(0, 3'b001, 32'h8000_0000, 0, 32'h9ABC_7234, 0, 0);
    access(0, 3'b000, 32'h8000_0001, 0, 32'h0000_7F00, 0, 0);
    access(1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 0, 0, 0);
    access(1, 3'b000, 32'h8000_0001, 32'h1234_56A5, 0, 0, 0);
    access(1, 3'b000, 32'h8000_0003, 32'h0000_00C3, 0, 0, 0);
    access(1, 3'b010, 32'h8000_0010, 32'hCAFE_F00D, 0, 0, 0);
    access(0, 3'b010, 32'h8000_0001, 0, 32'h1111_1111, 0, 0);
    access(1, 3'b011, 32'h8000_0000, 32'h2222_2222, 0, 0, 0);
    access(1, 3'b001, 32'h8000_0003, 32'h3333_3333, 0, 0, 0);
    access(0, 3'b110, 32'h8000_0000, 0, 32'h4444_4444, 0, 0);
    access(1, 3'b100, 32'h8000_0000, 32'h5555_5555, 0, 0, 0);
    access(1, 3'b010, 32'h8000_0020, 32'h0BAD_CAFE, 0, 5, 3);
    access(0, 3'b101, 32'h8000_0022, 0, 32'hF00D_8001, 5, 3);
    for (int n = 0; n < 20; n++)
      access($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2));
    req_valid = 1; req_write = 0; req_funct3 = 3'b010; req_addr = 32'h8000_0040;
    @(posedge clk); #1 req_valid = 0; mem_ready = 1;
    @(posedge clk); #1 mem_ready = 0; reset = 0;
    @(posedge clk); #1 reset = 1;
    check("abort_req_ready", req_ready, 1);
    check("abort_mem_valid", mem_valid, 0);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_mem_addr", mem_addr, 0);
    mem_rvalid = 1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1 mem_rvalid = 0;
    check("late_rvalid_resp", resp_valid, 0);
    check("late_rvalid_idle", req_ready, 1);
    access(0, 3'b010, 32'h8000_0044, 0, 32'h1357_9BDF, 0, 0);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
